axi_burst_alu_regs: RTL and testbench
=====================================

# axi_burst_alu_regs

AXI4 burst slave fronting a parametrised bank of NUM_REGS registers, the lowest four of which form an ALU: operand A, operand B, opcode, and a read-only result. It supports FIXED, INCR and WRAP bursts of up to 256 beats, byte strobes and SLVERR reporting, with independent read and write channels. It is the memory-mapped compute endpoint on the AXI_MM_BURST interconnect.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; a power of 2, at least 8.
- NUM_REGS, 16, register count; a power of 2, at least 4.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- awaddr/awlen/awsize/awburst  in  ADDR_WIDTH/8/3/2  write address, beats-1, log2 bytes per beat, burst type.
- awvalid in 1, awready out 1: AW handshake.
- wdata in DATA_WIDTH, wstrb in DATA_WIDTH/8, wlast in 1, wvalid in 1, wready out 1: W channel.
- bresp out 2, bvalid out 1, bready in 1: B channel.
- araddr/arlen/arsize/arburst  in  ADDR_WIDTH/8/3/2  read address fields.
- arvalid in 1, arready out 1: AR handshake.
- rdata out DATA_WIDTH, rresp out 2, rlast out 1, rvalid out 1, rready in 1: R channel.

## Operation
- Address map:
  - OFS = log2(DATA_WIDTH/8); the word index is addr >> OFS.
  - Index 0 is OP_A, 1 is OP_B, 2 is OPCODE, 3 is RESULT (read-only), 4..NUM_REGS-1 are scratch.
  - An index at or above NUM_REGS is out of range. The full address width is compared; there is no aliasing.
- Burst error checks (burst-level SLVERR):
  - size ≠ OFS.
  - burst = 2'b11.
  - WRAP with len not in {1,3,7,15}.
- Address progression per beat:
  - FIXED: the address is unchanged.
  - INCR: the word index increases by 1 with full-width arithmetic, so beats past the top of the bank are out of range.
  - WRAP: the index wraps within the (len+1)-word aligned window.
- Write FSM: W_IDLE → W_DATA on AW handshake → W_RESP on the terminating beat → W_IDLE on B handshake.
  - W_IDLE: awready=1; AW fields are captured.
  - W_DATA: wready=1; each beat writes the bytes enabled by wstrb.
  - A beat is suppressed and marks the burst SLVERR if it is out of range, targets RESULT, or follows a burst-level error.
  - The burst terminates on wlast or on beat len+1, whichever comes first. If wlast does not coincide with beat len+1, the response is SLVERR.
  - W_RESP: bvalid=1; bresp=2'b00 OKAY, or 2'b10 SLVERR if any error was marked.
- Read FSM: R_IDLE → R_DATA on AR handshake → R_IDLE on the handshake of the last beat.
  - rdata is registered. rlast=1 on beat len+1.
  - An errored beat returns rdata=0 and rresp=2'b10; other beats return 2'b00.
  - All len+1 beats are always returned.
- ALU: RESULT is registered and recomputed the cycle after any write to indices 0–2. Opcodes:
  - 0: A+B.
  - 1: A−B (modulo 2^DATA_WIDTH).
  - 2: ~A.
  - 3: A<<B; the result is 0 if B ≥ DATA_WIDTH.
  - 4: A&B.
  - 5: A|B.
  - 6: A^B.
  - Other values give 0.
- Channel concurrency: read and write FSMs run concurrently. If a read beat loads a register in the same cycle as a write to it, the read returns the pre-write value.

## Timing
- Reset: while rst is high, all outputs are 0, all registers are 0, and both FSMs are idle. awready and arready go to 1 the first cycle after rst falls.
- Reset mid-burst abandons the burst; no B or R completion is issued.
- Write: AW handshake in cycle N gives wready=1 in N+1. Throughput is 1 beat/cycle while wvalid is high.
- Write response: last W beat in cycle M gives bvalid in M+1. bvalid and bresp are held until bready; awready=1 the cycle after the B handshake.
- Read: AR handshake in cycle N gives the first rvalid in N+1. The next beat is presented the cycle after each R handshake, so throughput is 1 beat/cycle with rready held.
- Stall behaviour: rdata, rresp and rlast are stable while rvalid=1 and rready=0. bresp is stable while bvalid=1 and bready=0.
- Outstanding transactions: one per direction; awready=0 outside W_IDLE and arready=0 outside R_IDLE.
- RESULT readback: RESULT is valid for read 1 cycle after the final operand or opcode write beat.

## Structure
- Package axi_burst_pkg holds:
  - Burst constants: FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - Response constants: OKAY=2'b00, SLVERR=2'b10.
  - The ALU opcode enum.
  - The write and read FSM state typedefs.
  - Fixed register indices 0–3.
- Sub-module axi_burst_addr_gen computes the next word index and the range and WRAP-legality flags from addr, len, size and burst. It is instantiated once per channel.

## Test plan
- Single writes: 5→OP_A, 3→OP_B, 1→OPCODE, then read index 3 → 2, OKAY; with opcode 3 and B=40 (DATA_WIDTH=32) → 0.
- INCR write of len=3 at index 4 with data 0xA..0xD, then INCR read of len=3 → 0xA..0xD, rlast on beat 4 only, 4× OKAY.
- WRAP read of len=3 starting at index 6 → indices 6,7,4,5; WRAP with len=2 → SLVERR on every beat, rdata=0.
- INCR write of len=3 at index NUM_REGS-2 → first two beats are written, bresp=SLVERR, no other register is changed.
- Write to RESULT or with wstrb=4'b0010 → RESULT unchanged with SLVERR; with the strobe, only byte 1 is updated.
- rready toggled 1/0 during an 8-beat read → rdata stable while stalled, no beats lost. Assert rst mid-write → all registers 0, bvalid never rises.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// Shared constants and types for the AXI burst ALU register endpoint.
// Holds burst/response encodings, fixed register indices, the ALU opcode
// enum and the write/read channel state typedefs.
package axi_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int IDX_OP_A   = 0;
  localparam int IDX_OP_B   = 1;
  localparam int IDX_OPCODE = 2;
  localparam int IDX_RESULT = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_SHL = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address helper for one AXI channel.
// Ports:
//   addr       in   current byte address of the beat
//   len/size/burst in  burst attributes (beats-1, log2 bytes, type)
//   next_addr  out  byte address of the following beat (word aligned)
//   reg_idx    out  low word-index bits selecting a register
//   in_range   out  full-width word index is below NUM_REGS
//   wrap_ok    out  burst is not WRAP, or WRAP with a legal length
//   burst_err  out  beat size mismatch or reserved burst type
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [7:0]                  len,
  input  logic [2:0]                  size,
  input  logic [1:0]                  burst,
  output logic [ADDR_WIDTH-1:0]       next_addr,
  output logic [$clog2(NUM_REGS)-1:0] reg_idx,
  output logic                        in_range,
  output logic                        wrap_ok,
  output logic                        burst_err
);

  localparam int OFS = $clog2(DATA_WIDTH / 8);
  localparam int IW  = $clog2(NUM_REGS);

  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_idx;

  assign idx       = addr >> OFS;
  assign idx_inc   = idx + ADDR_WIDTH'(1);
  // Legal WRAP lengths are 2^n-1, so len itself is the in-window index mask.
  assign wrap_mask = ADDR_WIDTH'(len);

  always_comb begin
    next_idx = idx;
    case (burst)
      BURST_INCR: next_idx = idx_inc;
      BURST_WRAP: next_idx = (idx & ~wrap_mask) | (idx_inc & wrap_mask);
      default:    next_idx = idx;
    endcase
  end

  assign next_addr = next_idx << OFS;
  assign reg_idx   = idx[IW-1:0];
  assign in_range  = (idx < ADDR_WIDTH'(NUM_REGS));
  assign wrap_ok   = (burst != BURST_WRAP) ||
                     (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  assign burst_err = (size != 3'(OFS)) || (burst == 2'b11);

endmodule

// File: rtl/axi_burst_alu_regs.sv
// AXI4 burst slave over a bank of NUM_REGS registers; indices 0..3 are an
// ALU (operand A, operand B, opcode, read-only result), the rest scratch.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   aw*/w*/b*                    write address, data and response channels
//   ar*/r*                       read address and data channels
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting write beats
// W_RESP | bvalid high, holding bresp until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, presenting the current read beat
module axi_burst_alu_regs
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_upd;

  // ---------------- write channel ----------------
  w_state_e              w_state;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q;
  logic [7:0]            w_cnt;
  logic                  w_err;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [IW-1:0]         w_idx;
  logic                  w_in_range, w_wrap_ok, w_burst_err;
  logic                  w_beat, w_beat_err, w_last_beat, w_done, wr_en;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_w_addr_gen (
    .addr      (aw_addr_q),
    .len       (aw_len_q),
    .size      (aw_size_q),
    .burst     (aw_burst_q),
    .next_addr (w_next_addr),
    .reg_idx   (w_idx),
    .in_range  (w_in_range),
    .wrap_ok   (w_wrap_ok),
    .burst_err (w_burst_err)
  );

  assign w_beat      = wready && wvalid;
  assign w_beat_err  = w_burst_err || !w_wrap_ok || !w_in_range ||
                       (w_idx == IW'(IDX_RESULT));
  assign w_last_beat = (w_cnt == aw_len_q);
  assign w_done      = w_beat && (wlast || w_last_beat);
  assign wr_en       = w_beat && !w_beat_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state    <= W_IDLE;
      awready    <= 1'b0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt      <= '0;
      w_err      <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            aw_addr_q  <= awaddr;
            aw_len_q   <= awlen;
            aw_size_q  <= awsize;
            aw_burst_q <= awburst;
            w_cnt      <= '0;
            w_err      <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (w_done) begin
              // wlast and the len+1 count must agree, otherwise the burst is malformed.
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_beat_err || (wlast != w_last_beat)) ?
                         RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_err     <= w_err || w_beat_err;
              aw_addr_q <= w_next_addr;
              w_cnt     <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- register bank and ALU ----------------
  always_comb begin
    alu_result = '0;
    if (regs[IDX_OPCODE] <= DATA_WIDTH'(ALU_XOR)) begin
      case (alu_op_e'(regs[IDX_OPCODE][2:0]))
        ALU_ADD: alu_result = regs[IDX_OP_A] + regs[IDX_OP_B];
        ALU_SUB: alu_result = regs[IDX_OP_A] - regs[IDX_OP_B];
        ALU_NOT: alu_result = ~regs[IDX_OP_A];
        ALU_SHL: alu_result = (regs[IDX_OP_B] >= DATA_WIDTH'(DATA_WIDTH)) ?
                              '0 : (regs[IDX_OP_A] << regs[IDX_OP_B]);
        ALU_AND: alu_result = regs[IDX_OP_A] & regs[IDX_OP_B];
        ALU_OR:  alu_result = regs[IDX_OP_A] | regs[IDX_OP_B];
        ALU_XOR: alu_result = regs[IDX_OP_A] ^ regs[IDX_OP_B];
        default: alu_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      result_q <= '0;
      alu_upd  <= 1'b0;
    end else begin
      // Result follows one cycle behind the operand/opcode write that changed it.
      alu_upd <= wr_en && (w_idx < IW'(IDX_RESULT));
      if (wr_en) begin
        for (int b = 0; b < SW; b++) begin
          if (wstrb[b]) regs[w_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (alu_upd) result_q <= alu_result;
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic [7:0]            r_cnt;

  logic [ADDR_WIDTH-1:0] rg_addr;
  logic [7:0]            rg_len;
  logic [2:0]            rg_size;
  logic [1:0]            rg_burst;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [IW-1:0]         r_idx;
  logic                  r_in_range, r_wrap_ok, r_burst_err, r_beat_err;
  logic [DATA_WIDTH-1:0] r_beat_data;

  // While idle the first beat is looked up straight from the AR inputs so it
  // can be registered on the handshake edge.
  assign rg_addr  = (r_state == R_IDLE) ? araddr  : ar_addr_q;
  assign rg_len   = (r_state == R_IDLE) ? arlen   : ar_len_q;
  assign rg_size  = (r_state == R_IDLE) ? arsize  : ar_size_q;
  assign rg_burst = (r_state == R_IDLE) ? arburst : ar_burst_q;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_r_addr_gen (
    .addr      (rg_addr),
    .len       (rg_len),
    .size      (rg_size),
    .burst     (rg_burst),
    .next_addr (r_next_addr),
    .reg_idx   (r_idx),
    .in_range  (r_in_range),
    .wrap_ok   (r_wrap_ok),
    .burst_err (r_burst_err)
  );

  assign r_beat_err = r_burst_err || !r_wrap_ok || !r_in_range;

  always_comb begin
    r_beat_data = '0;
    if (!r_beat_err) begin
      r_beat_data = (r_idx == IW'(IDX_RESULT)) ? result_q : regs[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_IDLE;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
      rlast      <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            ar_addr_q  <= r_next_addr;
            ar_len_q   <= arlen;
            ar_size_q  <= arsize;
            ar_burst_q <= arburst;
            r_cnt      <= '0;
            arready    <= 1'b0;
            rvalid     <= 1'b1;
            rdata      <= r_beat_data;
            rresp      <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
            rlast      <= (arlen == 8'd0);
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rdata   <= '0;
              rresp   <= RESP_OKAY;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rdata     <= r_beat_data;
              rresp     <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
              rlast     <= ((r_cnt + 8'd1) == ar_len_q);
              ar_addr_q <= r_next_addr;
              r_cnt     <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_alu_regs.sv
`timescale 1ns/1ps
module tb_axi_burst_alu_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;

  always #5 clk = ~clk;

  axi_burst_alu_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mregs [NR];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  function automatic bit model_burst_err(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
    return (size != 3'd2) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic longint unsigned beat_index(input logic [31:0] addr, input logic [7:0] len,
                                                 input logic [1:0] burst, input int i);
    longint unsigned start, n, base;
    start = longint'(addr >> 2);
    n     = longint'(len) + 1;
    case (burst)
      2'b01: return (start + longint'(i)) % (64'd1 << 30);
      2'b10: begin
        base = start - (start % n);
        return base + ((start - base + longint'(i)) % n);
      end
      default: return start;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] a, b, op;
    a = mregs[0]; b = mregs[1]; op = mregs[2];
    case (op)
      32'd0: return a + b;
      32'd1: return a - b;
      32'd2: return ~a;
      32'd3: return (b >= 32) ? 32'd0 : (a << b);
      32'd4: return a & b;
      32'd5: return a | b;
      32'd6: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input logic [2:0] size,
                                             input int nbeats);
    bit berr, err;
    longint unsigned idx;
    berr = model_burst_err(len, size, burst);
    err  = berr;
    for (int i = 0; i < nbeats; i++) begin
      idx = beat_index(addr, len, burst, i);
      if (berr || idx >= NR || idx == 3) err = 1'b1;
      else
        for (int bb = 0; bb < 4; bb++)
          if (ws[i][bb]) mregs[int'(idx)][8*bb +: 8] = wd[i][8*bb +: 8];
    end
    if (nbeats != int'(len) + 1) err = 1'b1;
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic model_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input int i,
                            output logic [31:0] data, output logic [1:0] resp);
    longint unsigned idx;
    idx = beat_index(addr, len, burst, i);
    if (model_burst_err(len, size, burst) || idx >= NR) begin
      data = 32'd0; resp = 2'b10;
    end else begin
      data = (idx == 3) ? model_result() : mregs[int'(idx)];
      resp = 2'b00;
    end
  endtask

  // ---------------- bus tasks ----------------
  task automatic aw_hs(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                       input logic [2:0] s);
    int t = 0;
    awaddr = a; awlen = l; awburst = b; awsize = s; awvalid = 1'b1;
    while (!awready && t < 100) begin @(posedge clk); #1; t++; end
    check_val("awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    check_val("wready_after_aw", wready, 1);
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] st, input logic last);
    int t = 0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    wdata = d; wstrb = st; wlast = last; wvalid = 1'b1;
    while (!wready && t < 100) begin @(posedge clk); #1; t++; end
    check_val("wready", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                           input logic [2:0] s, input int nbeats);
    logic [1:0] exp;
    int t = 0;
    int gap;
    exp = model_write(a, l, b, s, nbeats);
    aw_hs(a, l, b, s);
    for (int i = 0; i < nbeats; i++) w_beat(wd[i], ws[i], (i == nbeats - 1));
    check_val("bvalid_after_last_w", bvalid, 1);
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check_val("bresp_hold", {bvalid, bresp}, {1'b1, exp});
    end
    bready = 1'b1;
    while (!bvalid && t < 100) begin @(posedge clk); #1; t++; end
    check_val("bresp", {bvalid, bresp}, {1'b1, exp});
    @(posedge clk); #1;
    bready = 1'b0;
    check_val("b_done", {bvalid, awready}, 2'b01);
  endtask

  // mode 0: rready held, 1: toggled each cycle, 2: random
  task automatic axi_read(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [2:0] s, input int mode);
    int t = 0;
    int got = 0;
    logic [31:0] ed;
    logic [1:0]  er;
    araddr = a; arlen = l; arburst = b; arsize = s; arvalid = 1'b1;
    while (!arready && t < 100) begin @(posedge clk); #1; t++; end
    check_val("arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check_val("rvalid_after_ar", rvalid, 1);
    t = 0;
    while (got < int'(l) + 1 && t < 2000) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : ($urandom_range(0, 2) != 0);
      if (rvalid) begin
        model_read(a, l, b, s, got, ed, er);
        check_val("rdata", rdata, ed);
        check_val("rresp", rresp, er);
        check_val("rlast", rlast, (got == int'(l)));
        if (rready) got++;
      end
      @(posedge clk); #1;
      t++;
    end
    rready = 1'b0;
    check_val("r_beats", got, int'(l) + 1);
    check_val("r_done", {rvalid, arready}, 2'b01);
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin wd[i] = base + i; ws[i] = 4'hF; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] ra;
  logic [7:0]  rl;
  logic [1:0]  rb;
  logic [2:0]  rs;
  int          nb;

  initial begin
    for (int i = 0; i < NR; i++) mregs[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", {awready, arready, wready, bvalid, bresp, rvalid, rresp, rlast}, 0);
    check_val("reset_rdata", rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("ready_after_reset", {awready, arready}, 2'b11);

    // single ALU writes: 5 - 3
    fill(1, 5);  axi_write(32'h0, 0, 2'b01, 2, 1);
    fill(1, 3);  axi_write(32'h4, 0, 2'b01, 2, 1);
    fill(1, 1);  axi_write(32'h8, 0, 2'b01, 2, 1);
    axi_read(32'hC, 0, 2'b01, 2, 0);
    // shift by 40 gives 0
    fill(1, 40); axi_write(32'h4, 0, 2'b01, 2, 1);
    fill(1, 3);  axi_write(32'h8, 0, 2'b01, 2, 1);
    axi_read(32'hC, 0, 2'b00, 2, 0);

    // INCR write/read at index 4
    fill(4, 32'hA); axi_write(32'h10, 3, 2'b01, 2, 4);
    axi_read(32'h10, 3, 2'b01, 2, 0);
    // WRAP legal and illegal
    axi_read(32'h18, 3, 2'b10, 2, 0);
    axi_read(32'h18, 2, 2'b10, 2, 0);
    // INCR running past the top of the bank
    fill(4, 32'h5000); axi_write((NR - 2) * 4, 3, 2'b01, 2, 4);
    axi_read(32'h0, 15, 2'b01, 2, 0);
    // write to RESULT, then byte-1 strobe on scratch
    fill(1, 32'hDEAD); axi_write(32'hC, 0, 2'b01, 2, 1);
    wd[0] = 32'h11223344; ws[0] = 4'hF; axi_write(32'h20, 0, 2'b01, 2, 1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0010; axi_write(32'h20, 0, 2'b01, 2, 1);
    axi_read(32'h20, 0, 2'b01, 2, 0);
    axi_read(32'hC, 0, 2'b01, 2, 0);
    // stalled 8-beat read
    axi_read(32'h0, 7, 2'b01, 2, 1);
    // out of range, no aliasing, size error, early wlast
    axi_read(32'h1000_0000, 1, 2'b00, 2, 0);
    axi_read(32'h40, 0, 2'b01, 2, 0);
    fill(1, 32'h77); axi_write(32'h24, 0, 2'b01, 1, 1);
    fill(2, 32'h900); axi_write(32'h24, 3, 2'b01, 2, 2);
    axi_read(32'h20, 7, 2'b01, 2, 2);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      rb = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'b11;
      if (rb == 2'b10 && $urandom_range(0, 3) != 0) rl = 8'((2 << $urandom_range(0, 3)) - 1);
      else rl = 8'($urandom_range(0, 7));
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      ra = 32'($urandom_range(0, NR + 3)) << 2;
      if ($urandom_range(0, 15) == 0) ra[31] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(rl); i++) begin
          wd[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom();
          ws[i] = 4'($urandom_range(0, 15));
        end
        nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, int'(rl) + 1) : int'(rl) + 1;
        axi_write(ra, rl, rb, rs, nb);
      end else begin
        axi_read(ra, rl, rb, rs, $urandom_range(0, 2));
      end
    end
    axi_read(32'h0, 15, 2'b01, 2, 0);

    // reset in the middle of a write burst
    aw_hs(32'h10, 3, 2'b01, 2);
    w_beat(32'h1, 4'hF, 1'b0);
    w_beat(32'h2, 4'hF, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("mid_reset_outs", {awready, arready, wready, bvalid, rvalid}, 0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_val("no_bvalid_after_reset", bvalid, 0);
    end
    axi_read(32'h0, 15, 2'b01, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
